uart_tx_scheduler: RTL



---
 rtl/uart_tx_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler in front of the UART TX FIFO, with drain-then-handshake
// sequencing of line-configuration changes.
module uart_tx_scheduler #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned MAX_BURST     = 4,
    parameter int unsigned TX_FIFO_DEPTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    input  logic                 cfg_update_i,
    input  logic [1:0]           cfg_data_width_i,
    input  logic [1:0]           cfg_stop_bits_i,
    output logic                 cfg_busy_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_fifo_write_o,
    input  logic                 tx_fifo_full_i,
    input  logic                 tx_done_i,
    output logic                 config_req_mst_o,
    input  logic                 req_done_i,
    output logic [1:0]           data_width_o,
    output logic [1:0]           stop_bits_number_o,
    output logic                 protocol_err_o
);

    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned CNT_W   = $clog2(TX_FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, GRANT, DRAIN, CFG_REQ, APPLY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic               pending_q, pending_d;
    logic [1:0]         shadow_width_q, shadow_width_d;
    logic [1:0]         shadow_stop_q, shadow_stop_d;
    logic [1:0]         width_q, width_d;
    logic [1:0]         stop_q, stop_d;
    logic               creq_q, creq_d;
    logic               err_q, err_d;

    logic               owner_valid;
    logic               xfer;
    logic               cfg_capture;
    logic               pending_now;
    logic [BURST_W-1:0] burst_inc;
    logic [IDX_W:0]     idx;
    logic [IDX_W-1:0]   pick;
    logic               pick_found;

    // First valid producer at or after the round-robin pointer, wrapping around.
    always_comb begin
        idx        = '0;
        pick       = rr_q;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(N_REQ)) begin
                idx = idx - (IDX_W+1)'(N_REQ);
            end
            if (!pick_found && req_valid_i[idx[IDX_W-1:0]]) begin
                pick       = idx[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    // Zero-latency write path from the current owner to the FIFO.
    always_comb begin
        req_ready_o = '0;
        xfer        = 1'b0;
        owner_valid = req_valid_i[owner_q];
        if (state_q == GRANT) begin
            req_ready_o[owner_q] = !tx_fifo_full_i;
            xfer                 = owner_valid && !tx_fifo_full_i;
        end
        tx_fifo_write_o = xfer;
        tx_data_o       = xfer ? req_data_i[{owner_q, 3'b000} +: 8] : 8'h00;
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_d           = rr_q;
        grant_d        = grant_q;
        burst_d        = burst_q;
        outst_d        = outst_q;
        pending_d      = pending_q;
        shadow_width_d = shadow_width_q;
        shadow_stop_d  = shadow_stop_q;
        width_d        = width_q;
        stop_d         = stop_q;
        creq_d         = creq_q;
        err_d          = err_q;
        burst_inc      = burst_q + BURST_W'(1);

        cfg_capture = cfg_update_i && (state_q inside {IDLE, GRANT, DRAIN});
        pending_now = pending_q || cfg_capture;
        if (cfg_capture) begin
            shadow_width_d = cfg_data_width_i;
            shadow_stop_d  = cfg_stop_bits_i;
            pending_d      = 1'b1;
        end

        // A write and a completed frame in the same cycle cancel out.
        if (xfer && !tx_done_i) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (tx_done_i && !xfer) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_now) begin
                    state_d = DRAIN;
                end else if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick;
                    grant_d = N_REQ'(1) << pick;
                end
            end
            GRANT: begin
                if (xfer) begin
                    burst_d = burst_inc;
                end
                if ((xfer && burst_inc == BURST_W'(MAX_BURST)) || !owner_valid || pending_now) begin
                    state_d = pending_now ? DRAIN : IDLE;
                    grant_d = '0;
                    burst_d = '0;
                    rr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    state_d = CFG_REQ;
                    creq_d  = 1'b1;
                end
            end
            CFG_REQ: begin
                if (req_done_i) begin
                    state_d = APPLY;
                    creq_d  = 1'b0;
                end
            end
            APPLY: begin
                width_d   = shadow_width_q;
                stop_d    = shadow_stop_q;
                pending_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            rr_q           <= '0;
            grant_q        <= '0;
            burst_q        <= '0;
            outst_q        <= '0;
            pending_q      <= 1'b0;
            shadow_width_q <= 2'b11;
            shadow_stop_q  <= 2'b00;
            width_q        <= 2'b11;
            stop_q         <= 2'b00;
            creq_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_q           <= rr_d;
            grant_q        <= grant_d;
            burst_q        <= burst_d;
            outst_q        <= outst_d;
            pending_q      <= pending_d;
            shadow_width_q <= shadow_width_d;
            shadow_stop_q  <= shadow_stop_d;
            width_q        <= width_d;
            stop_q         <= stop_d;
            creq_q         <= creq_d;
            err_q          <= err_d;
        end
    end

    assign grant_o            = grant_q;
    assign config_req_mst_o   = creq_q;
    assign data_width_o       = width_q;
    assign stop_bits_number_o = stop_q;
    assign protocol_err_o     = err_q;
    assign cfg_busy_o         = pending_q || (state_q inside {DRAIN, CFG_REQ, APPLY});

endmodule
